// File: rtl/io_input_conditioner_if.sv
// Board-pin side of the input conditioner: raw switch/button pins in,
// synchronised/debounced words and per-button edge pulses out.
interface io_input_conditioner_if #(
  parameter int N_SW  = 18,
  parameter int N_BTN = 4
);
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_raw;
  logic [31:0]      io_sw;
  logic [31:0]      io_btn;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output sw_raw, btn_raw,
    input  io_sw, io_btn, btn_press, btn_release
  );
  modport slave (
    input  sw_raw, btn_raw,
    output io_sw, io_btn, btn_press, btn_release
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Two-flop synchronisers for all switches/buttons plus a per-button debounce
// counter; feeds the LSU input-mapped sw/btn words and press/release pulses.
module io_btn_debounce #(
  parameter int DB_CYCLES  = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_press,
  output logic o_release
);
  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          btn_s;

  // Normalise to 1 = pressed after the synchroniser, never before it.
  assign btn_s = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    sync1_d   = i_raw;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (btn_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d  = btn_s;
      cnt_d     = '0;
      press_d   = btn_s;
      release_d = ~btn_s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Sync flops reset to the released pin level so reset release is not a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_stable  = stable_q;
  assign o_press   = press_q;
  assign o_release = release_q;
endmodule

module io_input_conditioner #(
  parameter int N_SW           = 18,
  parameter int N_BTN          = 4,
  parameter int DB_CYCLES      = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  io_input_conditioner_if.slave bus
);
  logic [N_SW-1:0]  sw_sync1_q, sw_sync1_d;
  logic [N_SW-1:0]  sw_sync2_q, sw_sync2_d;
  logic [N_BTN-1:0] btn_stable, btn_press, btn_release;

  always_comb begin
    sw_sync1_d = bus.sw_raw;
    sw_sync2_d = sw_sync1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= sw_sync1_d;
      sw_sync2_q <= sw_sync2_d;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    io_btn_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_raw     (bus.btn_raw[g]),
      .o_stable  (btn_stable[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

  assign bus.io_sw       = 32'(sw_sync2_q);
  assign bus.io_btn      = 32'(btn_stable);
  assign bus.btn_press   = btn_press;
  assign bus.btn_release = btn_release;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed stimulus with a cycle-stamped expectation queue; an independent
// monitor compares at the falling edge and flags any unscheduled pulse.
module tb_io_input_conditioner;
  localparam int N_SW = 18, N_BTN = 4, DB = 8;

  typedef struct {
    int          cyc;
    logic [31:0] sw;
    logic [31:0] btn;
    logic [3:0]  pr;
    logic [3:0]  rl;
  } exp_t;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  exp_t q[$];

  io_input_conditioner_if #(.N_SW(N_SW), .N_BTN(N_BTN)) bus ();

  io_input_conditioner #(
    .N_SW(N_SW), .N_BTN(N_BTN), .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [31:0] sw, input logic [31:0] btn,
                      input logic [3:0] pr, input logic [3:0] rl);
    exp_t e;
    int   i;
    e.cyc = c; e.sw = sw; e.btn = btn; e.pr = pr; e.rl = rl;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge i_clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missed_check: entry for cyc %0d not compared (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("io_sw",   cyc, bus.io_sw,  e.sw);
        chk("io_btn",  cyc, bus.io_btn, e.btn);
        chk("press",   cyc, 32'(bus.btn_press),   32'(e.pr));
        chk("release", cyc, 32'(bus.btn_release), 32'(e.rl));
      end else if ((bus.btn_press | bus.btn_release) != 4'h0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_pulse @cyc %0d: press %h release %h expected 0",
                 cyc, bus.btn_press, bus.btn_release);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    int c, r;
    bus.sw_raw  = '0;
    bus.btn_raw = 4'hF;
    // 1: reset, checked during and after
    push(1, 0, 0, 0, 0);
    push(2, 0, 0, 0, 0);
    tick(3);
    i_rst_n = 1'b1;
    c = cyc;
    push(c + 1, 0, 0, 0, 0);
    push(c + 3, 0, 0, 0, 0);
    tick(4);

    // 2: switch path, two-edge latency
    c = cyc;
    bus.sw_raw = 18'h2A5A5;
    push(c + 1, 0, 0, 0, 0);
    push(c + 2, 32'h0002A5A5, 0, 0, 0);
    tick(4);

    // 3: press button 0
    c = cyc;
    bus.btn_raw[0] = 1'b0;
    push(c + 9,  32'h0002A5A5, 32'h0, 4'h0, 4'h0);
    push(c + 10, 32'h0002A5A5, 32'h1, 4'h1, 4'h0);
    push(c + 11, 32'h0002A5A5, 32'h1, 4'h0, 4'h0);
    tick(13);

    // 4: short glitches on button 1 never accepted
    for (int k = 0; k < 3; k++) begin
      bus.btn_raw[1] = 1'b0;
      tick(5);
      bus.btn_raw[1] = 1'b1;
      tick(3);
    end
    tick(4);
    push(cyc + 1, 32'h0002A5A5, 32'h1, 4'h0, 4'h0);
    tick(2);

    // 5: release button 0
    c = cyc;
    bus.btn_raw[0] = 1'b1;
    push(c + 9,  32'h0002A5A5, 32'h1, 4'h0, 4'h0);
    push(c + 10, 32'h0002A5A5, 32'h0, 4'h0, 4'h1);
    push(c + 11, 32'h0002A5A5, 32'h0, 4'h0, 4'h0);
    tick(13);

    // 6: all buttons pressed, reset mid-count, then full re-acceptance
    c = cyc;
    bus.btn_raw = 4'h0;
    tick(6);
    #1 i_rst_n = 1'b0;
    push(cyc + 1, 0, 0, 0, 0);
    push(cyc + 2, 0, 0, 0, 0);
    tick(2);
    i_rst_n = 1'b1;
    r = cyc;
    push(r + 1,  32'h0,        32'h0, 4'h0, 4'h0);
    push(r + 2,  32'h0002A5A5, 32'h0, 4'h0, 4'h0);
    push(r + 9,  32'h0002A5A5, 32'h0, 4'h0, 4'h0);
    push(r + 10, 32'h0002A5A5, 32'hF, 4'hF, 4'h0);
    push(r + 11, 32'h0002A5A5, 32'hF, 4'h0, 4'h0);

    // drain with a bounded wait
    for (int k = 0; k < 200 && q.size() > 0; k++) tick(1);
    if (q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, limit 100000");
    $fatal(1, "timeout");
  end
endmodule
